// File: rtl/menu_nav.sv
// Menu navigation controller: turns debounced L/R/C button levels into a cursor with
// wrap/saturate, auto-repeat, and IDLE/BROWSE/ACTIVE mode tracking with launch/exit pulses.
module menu_nav #(
  parameter int unsigned NUM_ITEMS     = 4,
  parameter int unsigned SEL_W         = 4,
  parameter bit          WRAP          = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             btnL,
  input  logic             btnR,
  input  logic             btnC,
  output logic [1:0]       mode,
  output logic [SEL_W-1:0] cursor,
  output logic [SEL_W-1:0] active_item,
  output logic             launch,
  output logic             exit_pulse
);

  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0]  DelayLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0]  PeriodLast = CntW'(REPEAT_PERIOD - 1);
  localparam logic [SEL_W-1:0] LastItem   = SEL_W'(NUM_ITEMS - 1);

  typedef enum logic [1:0] {
    ModeIdle   = 2'd0,
    ModeBrowse = 2'd1,
    ModeActive = 2'd2
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [SEL_W-1:0] cursor_q, cursor_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic             launch_q, launch_d;
  logic             exit_q, exit_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rep_q, rep_d;
  // Button bit order throughout: {L, R, C}.
  logic [2:0]       prev_q;
  logic [2:0]       block_q;

  logic [2:0]       btn, rise;
  logic             rise_l, rise_r, rise_c, both_rise;
  logic             hold_ok, rep_fire;
  logic [SEL_W-1:0] step_dn, step_up;

  assign btn    = {btnL, btnR, btnC};
  // block_q masks buttons that were already held while reset was asserted.
  assign rise   = btn & ~prev_q & ~block_q;
  assign rise_l = rise[2];
  assign rise_r = rise[1];
  assign rise_c = rise[0];
  assign both_rise = btnL & btnR & ~(prev_q[2] & prev_q[1]);

  assign step_dn = (cursor_q == '0)       ? (WRAP ? LastItem : '0)       : cursor_q - SEL_W'(1);
  assign step_up = (cursor_q == LastItem) ? (WRAP ? '0       : LastItem) : cursor_q + SEL_W'(1);

  assign hold_ok  = (mode_q == ModeBrowse) & (btnL ^ btnR) & ~btnC;
  assign rep_fire = hold_ok & (cnt_q == (rep_q ? PeriodLast : DelayLast));

  always_comb begin
    mode_d   = mode_q;
    cursor_d = cursor_q;
    active_d = active_q;
    launch_d = 1'b0;
    exit_d   = 1'b0;
    cnt_d    = '0;
    rep_d    = 1'b0;

    if (hold_ok) begin
      if (rep_fire) begin
        cnt_d = '0;
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
        rep_d = rep_q;
      end
    end

    unique case (mode_q)
      ModeIdle: begin
        if (rise_c) mode_d = ModeBrowse;
      end
      ModeBrowse: begin
        if (rise_c) begin
          mode_d   = ModeActive;
          active_d = cursor_q;
          launch_d = 1'b1;
        end else if (rise_l ^ rise_r) begin
          cursor_d = rise_l ? step_dn : step_up;
        end else if (rep_fire) begin
          cursor_d = btnL ? step_dn : step_up;
        end
      end
      ModeActive: begin
        // launch_q marks the first ACTIVE cycle, during which buttons are ignored.
        if (!launch_q && both_rise) begin
          mode_d = ModeBrowse;
          exit_d = 1'b1;
        end
      end
      default: mode_d = ModeIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q   <= ModeIdle;
      cursor_q <= '0;
      active_q <= '0;
      launch_q <= 1'b0;
      exit_q   <= 1'b0;
      cnt_q    <= '0;
      rep_q    <= 1'b0;
      prev_q   <= '0;
      block_q  <= btn;
    end else begin
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      active_q <= active_d;
      launch_q <= launch_d;
      exit_q   <= exit_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      prev_q   <= btn;
      block_q  <= '0;
    end
  end

  assign mode        = mode_q;
  assign cursor      = cursor_q;
  assign active_item = active_q;
  assign launch      = launch_q;
  assign exit_pulse  = exit_q;

endmodule

// File: doc/menu_nav.md
Name: menu_nav

Overview:
- Parametrised menu navigation controller for the board UI.
- Converts debounced button levels (btnL, btnR, btnC) into a cursor over NUM_ITEMS entries.
- Supports wrap or saturate at the list ends and auto-repeat while a direction button is held.
- Tracks idle/browse/active mode and emits one-cycle launch/exit pulses that the top-level display mux uses to switch between OLED and AVI task screens.

Parameters:
- NUM_ITEMS, 4: number of selectable entries; legal range 2..16.
- SEL_W, 4: width of cursor and active_item; must satisfy 2^SEL_W >= NUM_ITEMS.
- WRAP, 1: 1 = cursor wraps at the ends; 0 = cursor saturates at 0 and NUM_ITEMS-1.
- REPEAT_DELAY, 50_000_000: cycles a direction button is held before the first auto-repeat step.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat steps.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- btnL  in  1  left/previous button, debounced level synchronous to CLK.
- btnR  in  1  right/next button, debounced level synchronous to CLK.
- btnC  in  1  centre/confirm button, debounced level synchronous to CLK.
- mode  out  2  0 = IDLE, 1 = BROWSE, 2 = ACTIVE; 3 is never driven.
- cursor  out  SEL_W  currently highlighted entry.
- active_item  out  SEL_W  entry launched by the last confirm.
- launch  out  1  one-cycle pulse on entry to ACTIVE.
- exit_pulse  out  1  one-cycle pulse on ACTIVE to BROWSE.

Behaviour:
- Clock and reset: single clock domain, CLK; reset RST is synchronous and active-high.
- Reset values: mode = IDLE, cursor = 0, active_item = 0, launch = 0, exit_pulse = 0. Repeat counter and the previous-value registers of all buttons are cleared.
- Reset asserted mid-hold or mid-ACTIVE overrides everything in that cycle. Buttons still held when RST deasserts do not produce edges.
- Edge detect: rise_X = X & ~X_prev, per button. Registered previous values. All outputs are registered, so each action takes effect on the cycle after the edge.
- IDLE:
  - rise_C -> BROWSE; cursor unchanged.
  - L/R ignored.
- BROWSE, evaluated in priority order:
  - rise_C -> ACTIVE; active_item <= cursor; launch = 1 for one cycle; no cursor move that cycle, even if L/R also rise.
  - rise_L and rise_R in the same cycle -> no move.
  - rise_L -> step down; rise_R -> step up.
  - Step down: cursor == 0 -> NUM_ITEMS-1 if WRAP, else stays 0.
  - Step up: cursor == NUM_ITEMS-1 -> 0 if WRAP, else stays NUM_ITEMS-1.
- Auto-repeat (BROWSE only):
  - Counter starts at 0 on the rise of a single held direction button.
  - When the counter reaches REPEAT_DELAY-1: one step, counter reloads to 0, phase becomes "repeating".
  - In the repeating phase, each REPEAT_PERIOD-1 boundary gives one further step.
  - Release, both L and R high, btnC high, or leaving BROWSE: counter cleared, phase returns to "delay".
  - Counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)); it never wraps.
- ACTIVE:
  - Cursor frozen.
  - Rising edge of (btnL & btnR) -> BROWSE with exit_pulse = 1 for one cycle. This holds whether the buttons rise together or the second one arrives later.
  - btnC and single L/R presses are ignored.
  - The first cycle after entering ACTIVE ignores buttons already high.
- launch and exit_pulse are never high in the same cycle, and never high two consecutive cycles.
- active_item holds its value until the next launch, including through exit and IDLE.
- No path leads back to IDLE except RST.

Test Plan:
- Reset then navigate: RST for 2 cycles -> mode = 0, cursor = 0. Pulse btnC -> mode = 1. Three single btnR pulses -> cursor = 3.
- Wrap with NUM_ITEMS = 4, WRAP = 1: from cursor 3, pulse btnR -> 0; pulse btnL -> 3. With WRAP = 0: from 3, btnR -> stays 3; from 0, btnL -> stays 0.
- Auto-repeat with REPEAT_DELAY = 8, REPEAT_PERIOD = 4, NUM_ITEMS = 16, WRAP = 0: hold btnR for 20 cycles from cursor 0 -> steps at the edge, then +8 and +12/+16/+20 cycles. Cursor = 5 at release; no further change after release.
- Launch and exit: cursor 2 in BROWSE, pulse btnC -> next cycle mode = 2, active_item = 2, launch high exactly 1 cycle. btnR alone -> cursor stays 2. Press btnL, then btnR 3 cycles later while holding L -> exit_pulse 1 cycle, mode = 1.
- Simultaneous edges in BROWSE: btnL and btnR rise together -> cursor unchanged. btnC and btnR rise together -> mode = 2, active_item = pre-edge cursor, no step.
- Reset mid-operation: in ACTIVE with btnC held, assert RST for 1 cycle -> mode = 0, active_item = 0, no launch/exit pulse. Releasing and re-pressing btnC -> BROWSE.
